alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 8..64.
REQ-002 SHALL have parameter MULDIV_EN, default 1; 1 enables RV M-extension operations, 0 disables them.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port InValid  input  1  request valid.
REQ-006 SHALL have port InReady  output  1  unit can accept a request.
REQ-007 SHALL have port ALUOp  input  2  from MainControl: 00 load/store add, 01 branch subtract, 10 R-type, 11 I-type ALU.
REQ-008 SHALL have port Func7  input  7  instruction bits [31:25].
REQ-009 SHALL have port Func3  input  3  instruction bits [14:12].
REQ-010 SHALL have port OpA  input  XLEN  operand A.
REQ-011 SHALL have port OpB  input  XLEN  operand B (rs2 or immediate).
REQ-012 SHALL have port OutValid  output  1  result valid.
REQ-013 SHALL have port OutReady  input  1  consumer accepts result.
REQ-014 SHALL have port Result  output  XLEN  operation result.
REQ-015 SHALL have port Zero  output  1  Result == 0.
REQ-016 SHALL have port IllegalOp  output  1  undecodable or disabled operation.

Function
REQ-017 States SHALL be IDLE, MUL, DIV, DONE; InReady = 1 only in IDLE; OutValid = 1 only in DONE.
REQ-018 Accept occurs on a clk edge with InValid && InReady; ALUOp, Func7, Func3, OpA, OpB SHALL be captured then and later input changes ignored.
REQ-019 ALUOp 00 SHALL add; 01 SHALL compute OpA-OpB; Func fields ignored.
REQ-020 ALUOp 10 with Func7 0000000 SHALL decode Func3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and; Func7 0100000 SHALL decode 000 sub, 101 sra; other Func7/Func3 pairs except REQ-022 SHALL be illegal.
REQ-021 ALUOp 11 SHALL decode as REQ-020 but Func3 000 always add; Func7 checked only for Func3 001/101 (srli/srai via Func7[5]).
REQ-022 ALUOp 10 with Func7 0000001 SHALL decode Func3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-023 Shift amount SHALL be OpB[log2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN; slt/sltu results zero-extended 0/1.
REQ-024 Single-cycle ops: IDLE -> DONE at accept edge; OutValid high from next cycle (latency 1).
REQ-025 mul* ops SHALL use iterative shift-add over 2*XLEN-bit product, one bit per cycle: IDLE -> MUL -> DONE, OutValid asserted exactly XLEN+1 cycles after accept edge.
REQ-026 div/rem ops SHALL use restoring division, one quotient bit per cycle: IDLE -> DIV -> DONE, same XLEN+1 latency; signed ops on magnitudes with sign fix-up (remainder sign = dividend sign).
REQ-027 Divide by zero SHALL bypass DIV: quotient all ones, remainder = OpA, latency 1.
REQ-028 Signed overflow (OpA = most-negative, OpB = all ones) SHALL bypass DIV: div quotient = OpA, rem = 0, latency 1.
REQ-029 Illegal op, or M op with MULDIV_EN=0, SHALL go to DONE with Result 0, IllegalOp 1, latency 1; IllegalOp 0 otherwise.
REQ-030 In DONE, Result/Zero/IllegalOp SHALL hold stable until OutReady; DONE -> IDLE on clk edge with OutReady; no new accept that same edge.
REQ-031 InValid while not IDLE SHALL be ignored with no state change.
REQ-032 MULDIV_EN=0 SHALL remove MUL/DIV datapaths; those states unreachable.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, InReady 1 (while rst_n low: 0), OutValid 0, Result 0, Zero 0, IllegalOp 0, iteration counter 0.
REQ-034 rst_n assertion mid-MUL/DIV or in DONE SHALL discard the operation; first accept after release SHALL behave as from power-up.

Verification
REQ-035 XLEN=32: ALUOp 10, Func7 0100000, Func3 000, OpA 5, OpB 7 -> Result 0xFFFFFFFE, Zero 0, OutValid 1 cycle after accept.
REQ-036 mul OpA 0xFFFFFFFF, OpB 3 -> 0xFFFFFFFD at 33 cycles; mulhu same -> 0x00000002; mulh same -> 0xFFFFFFFF.
REQ-037 div OpA 20, OpB 0 -> 0xFFFFFFFF latency 1; rem same -> 20; div 0x80000000 / 0xFFFFFFFF -> 0x80000000, rem -> 0; div -7 / 2 -> 0xFFFFFFFD, rem -> 0xFFFFFFFF.
REQ-038 OutReady held low 5 cycles in DONE -> OutValid, Result constant, InReady 0, InValid pulses ignored; release -> IDLE next edge.
REQ-039 rst_n low 10 cycles into MUL -> OutValid 0 at once; after release, add 1+1 -> Result 2 with latency 1.
REQ-040 MULDIV_EN=0, mul request -> Result 0, IllegalOp 1, latency 1; ALUOp 10, Func7 0100000, Func3 111 -> IllegalOp 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer ALU with an optional iterative multiply/divide unit behind valid/ready handshakes
//   clk, rst_n          clock, asynchronous active-low reset
//   InValid, InReady    request handshake; operands and op fields are captured on accept
//   ALUOp, Func7, Func3 operation select from main control and instruction fields
//   OpA, OpB            operands (OpB is rs2 or the immediate)
//   OutValid, OutReady  result handshake; result holds until OutReady
//   Result, Zero        operation result and its zero flag
//   IllegalOp           undecodable or disabled operation
module alu_exec_unit #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Func7,
    input  logic [2:0]      Func3,
    input  logic [XLEN-1:0] OpA,
    input  logic [XLEN-1:0] OpB,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            IllegalOp
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;
    state_t            state_q;
    op_t               op, base_op, m_op;
    logic              std_f7, alt_f7;
    logic [2*XLEN-1:0] acc_q, acc_d, prod;
    logic [XLEN-1:0]   b_q, res_q, alu_r, ma, mb, quo, rem, fin;
    logic [XLEN:0]     sum, sh, diff;
    logic [SW-1:0]     cnt_q;
    logic              neg_q, rneg_q, hi_q, zero_q, ill_q;
    logic              sa, sb, is_mul, is_div, dz, ovf, slow;
    assign InReady   = rst_n && state_q == IDLE;
    assign OutValid  = state_q == DONE;
    assign Result    = res_q;
    assign Zero      = zero_q;
    assign IllegalOp = ill_q;
    always_comb begin
        case (Func3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
        case (Func3)
            3'b000:  m_op = OP_MUL;
            3'b001:  m_op = OP_MULH;
            3'b010:  m_op = OP_MULHSU;
            3'b011:  m_op = OP_MULHU;
            3'b100:  m_op = OP_DIV;
            3'b101:  m_op = OP_DIVU;
            3'b110:  m_op = OP_REM;
            default: m_op = OP_REMU;
        endcase
        std_f7 = Func7 == 7'b0000000;
        alt_f7 = Func7 == 7'b0100000;
        if (ALUOp == 2'b00)
            op = OP_ADD;
        else if (ALUOp == 2'b01)
            op = OP_SUB;
        else if (ALUOp == 2'b10)
            op = std_f7 ? base_op
               : (alt_f7 && Func3 == 3'b000) ? OP_SUB
               : (alt_f7 && Func3 == 3'b101) ? OP_SRA
               : (Func7 == 7'b0000001 && MULDIV_EN) ? m_op : OP_ILL;
        else
            op = (Func3 == 3'b001) ? (std_f7 ? OP_SLL : OP_ILL)
               : (Func3 == 3'b101) ? (std_f7 ? OP_SRL : alt_f7 ? OP_SRA : OP_ILL)
               : base_op;
    end
    always_comb begin
        sa     = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) && OpA[XLEN-1];
        sb     = (op == OP_MULH || op == OP_DIV || op == OP_REM) && OpB[XLEN-1];
        ma     = sa ? -OpA : OpA;
        mb     = sb ? -OpB : OpB;
        is_mul = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        dz     = OpB == '0;
        ovf    = (op == OP_DIV || op == OP_REM) && OpA == {1'b1, {(XLEN-1){1'b0}}} && &OpB;
        slow   = MULDIV_EN && (is_mul || (is_div && !dz && !ovf));
        // div/rem entries here are only the single-cycle bypass results (divide by zero, signed overflow)
        case (op)
            OP_ADD:  alu_r = OpA + OpB;
            OP_SUB:  alu_r = OpA - OpB;
            OP_SLL:  alu_r = OpA << OpB[SW-1:0];
            OP_SLT:  alu_r = XLEN'($signed(OpA) < $signed(OpB));
            OP_SLTU: alu_r = XLEN'(OpA < OpB);
            OP_XOR:  alu_r = OpA ^ OpB;
            OP_SRL:  alu_r = OpA >> OpB[SW-1:0];
            OP_SRA:  alu_r = $signed(OpA) >>> OpB[SW-1:0];
            OP_OR:   alu_r = OpA | OpB;
            OP_AND:  alu_r = OpA & OpB;
            OP_DIV:  alu_r = dz ? '1 : OpA;
            OP_DIVU: alu_r = '1;
            OP_REM:  alu_r = dz ? OpA : '0;
            OP_REMU: alu_r = OpA;
            default: alu_r = '0;
        endcase
    end
    // acc_q holds {partial product, multiplier} during MUL and {remainder, dividend/quotient} during DIV
    always_comb begin
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        sh    = acc_q[2*XLEN-1:XLEN-1];
        diff  = sh - {1'b0, b_q};
        acc_d = (state_q == MUL) ? {sum, acc_q[XLEN-1:1]}
              : {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], ~diff[XLEN]};
        prod  = neg_q ? -acc_d : acc_d;
        quo   = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem   = rneg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        fin   = (state_q == MUL) ? (hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0])
              : (hi_q ? rem : quo);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (InValid) begin
                    if (slow) begin
                        state_q <= is_mul ? MUL : DIV;
                        cnt_q   <= '0;
                        acc_q   <= {{XLEN{1'b0}}, is_mul ? mb : ma};
                        b_q     <= is_mul ? ma : mb;
                        neg_q   <= sa ^ sb;
                        rneg_q  <= sa;
                        hi_q    <= is_mul ? op != OP_MUL : (op == OP_REM || op == OP_REMU);
                    end else begin
                        state_q <= DONE;
                        res_q   <= alu_r;
                        zero_q  <= alu_r == '0;
                        ill_q   <= op == OP_ILL;
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SW'(XLEN-1)) begin
                        state_q <= DONE;
                        res_q   <= fin;
                        zero_q  <= fin == '0;
                        ill_q   <= 1'b0;
                    end
                end
                default: if (OutReady) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid1, in_valid0, out_ready, sel0;
    logic [1:0]  alu_op;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b;
    logic        in_ready1, out_valid1, zero1, ill1;
    logic        in_ready0, out_valid0, zero0, ill0;
    logic [31:0] result1, result0;
    logic        ir, ov, zf, il;
    logic [31:0] res;
    int          n_checks = 0;
    int          n_fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(in_valid1), .InReady(in_ready1),
        .ALUOp(alu_op), .Func7(func7), .Func3(func3), .OpA(op_a), .OpB(op_b),
        .OutValid(out_valid1), .OutReady(out_ready), .Result(result1), .Zero(zero1), .IllegalOp(ill1)
    );
    alu_exec_unit #(.XLEN(32), .MULDIV_EN(1'b0)) dut_nomd (
        .clk(clk), .rst_n(rst_n), .InValid(in_valid0), .InReady(in_ready0),
        .ALUOp(alu_op), .Func7(func7), .Func3(func3), .OpA(op_a), .OpB(op_b),
        .OutValid(out_valid0), .OutReady(out_ready), .Result(result0), .Zero(zero0), .IllegalOp(ill0)
    );

    assign ir  = sel0 ? in_ready0 : in_ready1;
    assign ov  = sel0 ? out_valid0 : out_valid1;
    assign zf  = sel0 ? zero0 : zero1;
    assign il  = sel0 ? ill0 : ill1;
    assign res = sel0 ? result0 : result1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] alu, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input bit md,
                         output logic [31:0] r, output bit ill, output int lat);
        longint sa, sb, ua, ub;
        bit alt, ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        alt = f7 == 7'h20;
        ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
        r   = 32'd0;
        ill = 1'b0;
        lat = 1;
        if (alu == 2'd0) r = a + b;
        else if (alu == 2'd1) r = a - b;
        else if (alu == 2'd2 && f7 == 7'h01) begin
            if (!md) ill = 1'b1;
            else begin
                lat = 33;
                case (f3)
                    3'd0: r = 32'(sa * sb);
                    3'd1: r = 32'((sa * sb) >>> 32);
                    3'd2: r = 32'((sa * ub) >>> 32);
                    3'd3: r = 32'((ua * ub) >> 32);
                    3'd4: r = (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'(sa / sb);
                    3'd5: r = (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
                    3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
                    default: r = (b == 0) ? a : 32'(ua % ub);
                endcase
                if (f3[2] && (b == 0 || (ovf && !f3[0]))) lat = 1;
            end
        end
        else if (alu == 2'd3 && f3 == 3'd0) r = a + b;
        else if ((alu == 2'd2 || f3 == 3'd1 || f3 == 3'd5) &&
                 !(f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
        else begin
            case (f3)
                3'd0: r = alt ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        if (ill) r = 32'd0;
    endtask

    task automatic issue(input string tag, input logic [1:0] alu, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input bit use0);
        logic [31:0] er;
        bit          eil;
        int          elat, lat;
        model(alu, f7, f3, a, b, !use0, er, eil, elat);
        @(negedge clk);
        sel0 = use0;
        alu_op = alu; func7 = f7; func3 = f3; op_a = a; op_b = b;
        in_valid1 = !use0;
        in_valid0 = use0;
        #1 check({tag, " in_ready"}, ir, 1);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
        alu_op = 2'($urandom); func7 = 7'($urandom); func3 = 3'($urandom);
        op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!ov && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " result"}, res, er);
        check({tag, " zero"}, zf, er == 32'd0);
        check({tag, " illegal"}, il, eil);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_clear"}, ov, 0);
        check({tag, " in_ready_back"}, ir, 1);
    endtask

    task automatic op(input string tag, input logic [1:0] alu, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input bit use0);
        issue(tag, alu, f7, f3, a, b, use0);
        release_out(tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready = 1'b0; sel0 = 1'b0;
        alu_op = 2'd0; func7 = 7'd0; func3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        check("reset in_ready", ir, 0);
        check("reset out_valid", ov, 0);
        check("reset result", res, 0);
        check("reset zero", zf, 0);
        check("reset illegal", il, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release in_ready", ir, 1);

        op("sub_5_7", 2'b10, 7'h20, 3'd0, 32'd5, 32'd7, 1'b0);
        op("mul", 2'b10, 7'h01, 3'd0, 32'hFFFFFFFF, 32'd3, 1'b0);
        op("mulhu", 2'b10, 7'h01, 3'd3, 32'hFFFFFFFF, 32'd3, 1'b0);
        op("mulh", 2'b10, 7'h01, 3'd1, 32'hFFFFFFFF, 32'd3, 1'b0);
        op("mulhsu", 2'b10, 7'h01, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        op("div_by0", 2'b10, 7'h01, 3'd4, 32'd20, 32'd0, 1'b0);
        op("rem_by0", 2'b10, 7'h01, 3'd6, 32'd20, 32'd0, 1'b0);
        op("div_ovf", 2'b10, 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        op("rem_ovf", 2'b10, 7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        op("div_neg", 2'b10, 7'h01, 3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
        op("rem_neg", 2'b10, 7'h01, 3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
        op("divu", 2'b10, 7'h01, 3'd5, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        op("remu", 2'b10, 7'h01, 3'd7, 32'd1000, 32'd7, 1'b0);
        op("ld_add", 2'b00, 7'h55, 3'd6, 32'hFFFFFFFF, 32'd1, 1'b0);
        op("br_sub", 2'b01, 7'h01, 3'd4, 32'd9, 32'd9, 1'b0);
        op("addi_f7", 2'b11, 7'h20, 3'd0, 32'd10, 32'd3, 1'b0);
        op("srai", 2'b11, 7'h20, 3'd5, 32'h80000000, 32'd4, 1'b0);
        op("slli_bad", 2'b11, 7'h20, 3'd1, 32'd1, 32'd4, 1'b0);
        op("andi_f7", 2'b11, 7'h55, 3'd7, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
        op("sll", 2'b10, 7'h00, 3'd1, 32'h00000001, 32'h0000003F, 1'b0);
        op("slt", 2'b10, 7'h00, 3'd2, 32'hFFFFFFFF, 32'd1, 1'b0);
        op("sltu", 2'b10, 7'h00, 3'd3, 32'hFFFFFFFF, 32'd1, 1'b0);
        op("r_ill", 2'b10, 7'h20, 3'd7, 32'd3, 32'd4, 1'b0);

        issue("hold", 2'b10, 7'h00, 3'd4, 32'h0F0F0000, 32'h00FF00FF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid1 = i[0];
            alu_op = 2'd0;
            op_a = $urandom;
            @(negedge clk);
            check("hold out_valid", ov, 1);
            check("hold result", res, 32'h0FF000FF);
            check("hold in_ready", ir, 0);
        end
        in_valid1 = 1'b0;
        release_out("hold");

        @(negedge clk);
        sel0 = 1'b0;
        alu_op = 2'b10; func7 = 7'h01; func3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_mul out_valid", ov, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", ov, 0);
        check("mid_rst in_ready", ir, 0);
        check("mid_rst result", res, 0);
        check("mid_rst illegal", il, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst release in_ready", ir, 1);
        op("post_rst_add", 2'b00, 7'h00, 3'd0, 32'd1, 32'd1, 1'b0);

        op("nomd_mul", 2'b10, 7'h01, 3'd0, 32'd5, 32'd7, 1'b1);
        op("nomd_r_ill", 2'b10, 7'h20, 3'd7, 32'd5, 32'd7, 1'b1);
        op("nomd_add", 2'b10, 7'h00, 3'd0, 32'd5, 32'd7, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [6:0] f7;
            logic [1:0] alu;
            case ($urandom_range(0, 4))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2, 3: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            alu = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b10;
            op($sformatf("rnd%0d", i), alu, f7, 3'($urandom), pick(), pick(), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
